// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the keypad debouncer: widths, idle row pattern,
// FSM state encoding and the row one-hot / row index helpers.
package key_debouncer_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int ROWS_W     = 4;
    localparam int COL_W      = 2;
    localparam int ROW_IDX_W  = $clog2(ROWS_W);

    localparam logic [ROWS_W-1:0] ROWS_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // True when exactly one row line is low (rows are active-low).
    function automatic logic rows_single_low(input logic [ROWS_W-1:0] r);
        logic [ROWS_W-1:0] low;
        low = ~r;
        return (low != '0) && ((low & (low - 1'b1)) == '0);
    endfunction

    // Index of the lowest-numbered low row line; only meaningful when one bit is low.
    function automatic logic [ROW_IDX_W-1:0] rows_low_index(input logic [ROWS_W-1:0] r);
        logic [ROW_IDX_W-1:0] idx;
        idx = '0;
        for (int i = ROWS_W - 1; i >= 0; i--) begin
            if (!r[i]) idx = ROW_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debouncer_sync_ff.sv
// Multi-stage synchronizer for asynchronous level inputs; resets to all-ones
// so idle (released) keypad rows are seen during and right after reset.
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the input through the flop chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '1;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Keypad debouncer: turns a bouncing row press plus the scanner column into a
// single 4-bit key code on a valid/ready handshake, rejects multi-key presses
// and records codes dropped while the consumer stalls.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no key; wait for a press (only once rows were seen released)
//   DEBOUNCE | rows held low; count down stable cycles, restart on any change
//   EMIT     | single cycle: load key code or flag overflow
//   RELEASE  | wait for rows to stay released for the debounce period
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ROWS_W-1:0]     rows,
    input  logic [COL_W-1:0]      count,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  multi_key,
    output logic                  overflow
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(SYNC_STAGES);

    logic [ROWS_W-1:0]     rows_s;
    logic                  pressed_s;
    state_t                state_q, state_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic [ROWS_W-1:0]     cap_q, cap_nxt;
    logic [KEY_CODE_W-1:0] code_q, code_nxt;
    logic                  valid_q, valid_nxt;
    logic                  multi_q, multi_nxt;
    logic                  ovf_q, ovf_nxt;
    // After reset the synchronizer still holds its all-ones reset value, so a key
    // held through reset would look like a fresh press. Arming waits until the
    // reset value has flushed and the real rows have been seen released.
    logic [FLUSH_W-1:0]    flush_q, flush_nxt;
    logic                  armed_q, armed_nxt;

    sync_ff #(
        .WIDTH  (ROWS_W),
        .STAGES (SYNC_STAGES)
    ) u_rows_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rows),
        .q     (rows_s)
    );

    assign pressed_s = ~&rows_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            cap_q   <= ROWS_IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            ovf_q   <= 1'b0;
            flush_q <= FLUSH_LOAD;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            cap_q   <= cap_nxt;
            code_q  <= code_nxt;
            valid_q <= valid_nxt;
            multi_q <= multi_nxt;
            ovf_q   <= ovf_nxt;
            flush_q <= flush_nxt;
            armed_q <= armed_nxt;
        end
    end

    // Next-state, counter, capture and handshake logic.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        cap_nxt   = cap_q;
        code_nxt  = code_q;
        valid_nxt = valid_q;
        multi_nxt = 1'b0;
        ovf_nxt   = ovf_q;
        flush_nxt = (flush_q != '0) ? flush_q - 1'b1 : flush_q;
        armed_nxt = armed_q | ((flush_q == '0) && !pressed_s);

        if (valid_q && key_ready) valid_nxt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pressed_s && armed_q) begin
                    state_nxt = ST_DEBOUNCE;
                    cap_nxt   = rows_s;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_DEBOUNCE: begin
                if (!pressed_s) begin
                    state_nxt = ST_IDLE;
                end else if (rows_s != cap_q) begin
                    cap_nxt = rows_s;
                    cnt_nxt = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    // Reload here so RELEASE starts a full release window.
                    cnt_nxt = CNT_LOAD;
                    if (rows_single_low(cap_q)) begin
                        state_nxt = ST_EMIT;
                    end else begin
                        multi_nxt = 1'b1;
                        state_nxt = ST_RELEASE;
                    end
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_EMIT: begin
                if (valid_q && !key_ready) begin
                    ovf_nxt = 1'b1;
                end else begin
                    code_nxt  = {rows_low_index(cap_q), count};
                    valid_nxt = 1'b1;
                end
                state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (pressed_s)           cnt_nxt   = CNT_LOAD;
                else if (cnt_q == '0)    state_nxt = ST_IDLE;
                else                     cnt_nxt   = cnt_q - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign multi_key = multi_q;
    assign overflow  = ovf_q;

endmodule
